mem_responder: RTL



---
 rtl/nitc_mem_pkg.sv | 13 +
 rtl/mem_array.sv | 38 +++
 rtl/mem_responder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/nitc_mem_pkg.sv
// Shared types and widths for the NITC-RISC24 wait-state memory responder.
package nitc_mem_pkg;

    localparam int WORD_W     = 16;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM with synchronous write and registered synchronous read.
// Only the read register is reset; the storage itself powers up undefined.
module mem_array
    import nitc_mem_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WORD_W-1:0]    din,
    output logic [WORD_W-1:0]    dout
);

    logic [WORD_W-1:0] mem [2**ADDR_BITS];
    logic [WORD_W-1:0] dout_q;

    // Store the word on an enabled write; contents survive reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= din;
        end
    end

    // Capture the addressed word on an enabled read; writes leave it untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q <= '0;
        end else if (en && !we) begin
            dout_q <= mem[addr];
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: accepts a word request, waits WAIT_CYCLES,
// performs the access, then pulses ready for one cycle.
// Optional feature macro: MEM_ERR_EN (out-of-range detection via err).
module mem_responder
    import nitc_mem_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              memwrite,
    input  logic [WORD_W-1:0] adr,
    input  logic [WORD_W-1:0] writedata,
    output logic [WORD_W-1:0] readdata,
    output logic              ready,
    output logic              err
);

`ifdef MEM_ERR_EN
    localparam int LATCH_W = WORD_W;
`else
    localparam int LATCH_W = ADDR_BITS;
`endif

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CYCLES[WAIT_CNT_W-1:0];

    mem_state_t              state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [LATCH_W-1:0]      adr_q, adr_d;
    logic [WORD_W-1:0]       wdata_q, wdata_d;
    logic                    we_q, we_d;
    logic                    access;
    logic                    oob;
    logic [WORD_W-1:0]       arrayDout;

    // Next state, counter and request latch; access fires on the WAIT->DONE edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        access  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (req) begin
                    adr_d   = adr[LATCH_W-1:0];
                    wdata_d = writedata;
                    we_d    = memwrite;
                    cnt_d   = WAIT_LOAD;
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    access  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and latched request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

`ifdef MEM_ERR_EN
    logic err_q;
    logic zeroRead_q;

    assign oob = |adr_q[WORD_W-1:ADDR_BITS];

    // Flag out-of-range accesses for their DONE cycle, and remember whether
    // the most recent read was out of range so readdata reads as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q      <= 1'b0;
            zeroRead_q <= 1'b0;
        end else begin
            err_q <= access & oob;
            if (access && !we_q) begin
                zeroRead_q <= oob;
            end
        end
    end

    assign err      = err_q;
    assign readdata = zeroRead_q ? '0 : arrayDout;
`else
    // Upper address bits are deliberately dropped so addresses alias.
    logic unusedAdrHi;
    assign unusedAdrHi = ^adr[WORD_W-1:ADDR_BITS];

    assign oob      = 1'b0;
    assign err      = 1'b0;
    assign readdata = arrayDout;
`endif

    assign ready = (state_q == DONE);

    mem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .en    (access & ~(we_q & oob)),
        .we    (we_q),
        .addr  (adr_q[ADDR_BITS-1:0]),
        .din   (wdata_q),
        .dout  (arrayDout)
    );

endmodule
